kb_cmd_scheduler: RTL and testbench
===================================

Name: kb_cmd_scheduler

Overview:
- Sits between the PS/2 scan-code receiver and game logic.
- Parses set-2 make/break/extended sequences and tracks held keys per player.
- Resolves conflicting directions and, once per frame_tick, schedules one packed 8-bit instruction word to the game over a valid/ready handshake.
- Instruction format: [7:4] player 1, [3:0] player 2; per nibble bit3 = fire, bits[2:0] = move (000 still, 100 left, 001 right, 010 up, 111 down). System words: 8'hFF reset, 8'hFE pause.

Parameters:
TIMEOUT_W, 16, width of prefix-timeout counter
PREFIX_TIMEOUT, 50000, clk cycles after an F0/E0 prefix with no following code before the parser returns to IDLE
DROP_W, 4, width of saturating dropped-frame counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
scan_code  in  8  byte from PS/2 receiver
scan_ready  in  1  one-cycle strobe, scan_code valid
frame_tick  in  1  one-cycle strobe per game frame
instr  out  8  scheduled instruction word
instr_valid  out  1  instr holds an untransferred word
instr_ready  in  1  game accepts instr
held_p1  out  5  {fire,up,down,left,right} held mask, player 1
held_p2  out  5  same, player 2
drop_count  out  DROP_W  frames lost to backpressure, saturating

Behaviour:
- Reset (async, reset=0): instr=0, instr_valid=0, held_p1/p2=0, drop_count=0, parser IDLE, timeout counter 0, last-direction regs cleared, reset/pause one-shots cleared.
- Parser FSM, advances only on scan_ready: IDLE --E0--> EXT; IDLE --F0--> BRK; EXT --F0--> EXT_BRK; any other byte in IDLE/EXT = make, in BRK/EXT_BRK = break; then back to IDLE. Timeout counter runs in the three prefix states; at PREFIX_TIMEOUT it returns to IDLE, no key action.
- Key map (non-extended): 1D W p1 up, 1B S p1 down, 1C A p1 left, 23 D p1 right, 29 space p1 fire, 70 keypad-0 p2 fire, 2D R reset, 4D P pause.
- Key map (extended): E0 75 up, E0 72 down, E0 6B left, E0 74 right, all p2.
- Extended 70 and all unmapped codes are ignored.
- Make sets the held bit; break clears it. Break of a non-held key has no effect. A repeated make (typematic) is idempotent.
- Make of a direction also loads that player's last-direction register.
- Make of R or P sets the corresponding one-shot flag; break is ignored.
- Direction resolution per player: the last-direction key wins while held. If it is released, fall back to fixed priority up > down > left > right among remaining held directions. None held -> 000.
- Scheduling on frame_tick with instr_valid=0: compose the word; instr_valid rises the next cycle (latency 1).
  - Reset one-shot pending -> 8'hFF, clear flag.
  - Else pause pending -> 8'hFE, clear flag.
  - Else {p1 nibble, p2 nibble}. If this equals 8'hFF, clear p2 fire, giving 8'hF7. A composed word 8'h00 does not assert valid.
  - Both one-shots pending: reset on this tick, pause on the next.
- Handshake: transfer occurs on a cycle with instr_valid & instr_ready; instr_valid falls the following cycle. instr is held stable while instr_valid=1.
- Backpressure: frame_tick while instr_valid=1 and no transfer that cycle keeps the pending word unchanged and increments drop_count, saturating at all-ones. One-shots stay pending.
- Same-cycle scan_ready and frame_tick: the word is composed from state before the scan update. The update applies that cycle and is visible at the next tick.
- Same-cycle transfer and frame_tick: the new word is composed and valid stays high with the new value.

Optional Feature:
KB_HOLD_EN
- Defined: held keys persist; every frame_tick re-reports all held keys (level semantics).
- Undefined: each player key make is a one-shot consumed by the next scheduled word; held_p1/p2 bits clear when consumed or on break; the last-direction rule still orders multiple pending directions.

Test Plan:
- Scan 1D, then frame_tick, ready=1 -> instr=8'h20 valid one cycle after tick; then F0 1D, tick -> no valid.
- E0 75, then E0 72 (both held), tick -> instr=8'h07. E0 F0 72, tick -> 8'h02 (falls back to up; KB_HOLD_EN defined).
- 29 1B 70 E0 72, tick -> 8'hF7 (collision rule), not 8'hFF.
- 2D and 4D, then two ticks -> 8'hFF then 8'hFE. Movement keys held meanwhile are deferred to the third tick.
- ready=0, three ticks with 1C held -> instr stays 8'h40, drop_count=2. Set ready=1 -> transfer, valid drops.
- F0 followed by idle PREFIX_TIMEOUT cycles, then 1C -> treated as make (held_p1=00010). Assert reset mid-sequence -> all outputs 0 immediately.

Source files
------------

// File: rtl/kb_cmd_scheduler.sv
// kb_cmd_scheduler: PS/2 set-2 parser, per-player key tracking and once-per-frame instruction scheduler.
// Optional macro KB_HOLD_EN: held keys persist and are re-reported every frame; otherwise each make is consumed by the next player word.
module kb_cmd_scheduler #(
  parameter int TIMEOUT_W      = 16,
  parameter int PREFIX_TIMEOUT = 50000,
  parameter int DROP_W         = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        scan_code,
  input  logic              scan_ready,
  input  logic              frame_tick,
  output logic [7:0]        instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [4:0]        held_p1,
  output logic [4:0]        held_p2,
  output logic [DROP_W-1:0] drop_count
);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t              state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                timeout;
  logic                key_ext, key_make, key_brk;
  logic [4:0]          k1, k2;
  logic                kr, kp;
  logic [4:0]          held_p1_q, held_p1_d, held_p2_q, held_p2_d;
  logic [3:0]          last_p1_q, last_p1_d, last_p2_q, last_p2_d;
  logic                rst_q, rst_d, pause_q, pause_d;
  logic [7:0]          instr_q, instr_d;
  logic                valid_q, valid_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic [3:0]          dir1, dir2;
  logic [7:0]          pw, word;
  logic                sched, player;
  logic [4:0]          con1, con2;

  function automatic logic [3:0] pick(input logic [3:0] held, input logic [3:0] last);
    logic [3:0] hl;
    hl = held & last;
    return |hl ? hl : held[3] ? 4'b1000 : held[2] ? 4'b0100 : held[1] ? 4'b0010 : held[0] ? 4'b0001 : 4'b0000;
  endfunction

  // one-hot {up,down,left,right} to move code: up 010, down 111, left 100, right 001
  function automatic logic [2:0] mv(input logic [3:0] d);
    return {d[2] | d[1], d[3] | d[2], d[2] | d[0]};
  endfunction

  // parser state and prefix-timeout counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // parser next state: prefixes advance, any other byte or a timeout returns to IDLE
  always_comb begin
    timeout = state_q != IDLE && !scan_ready && cnt_q == TIMEOUT_W'(PREFIX_TIMEOUT - 1);
    cnt_d   = (state_q != IDLE && !scan_ready && !timeout) ? cnt_q + 1'b1 : '0;
    state_d = state_q;
    if (scan_ready)
      state_d = (state_q == IDLE && scan_code == 8'hE0) ? EXT :
                (state_q == IDLE && scan_code == 8'hF0) ? BRK :
                (state_q == EXT  && scan_code == 8'hF0) ? EXT_BRK : IDLE;
    else if (timeout)
      state_d = IDLE;
  end

  // parser outputs: make/break events and key map decode
  always_comb begin
    key_ext  = state_q == EXT || state_q == EXT_BRK;
    key_brk  = scan_ready && (state_q == BRK || state_q == EXT_BRK);
    key_make = scan_ready && !key_brk && scan_code != 8'hF0 && !(state_q == IDLE && scan_code == 8'hE0);
    k1 = key_ext ? 5'b0 :
         scan_code == 8'h1D ? 5'b01000 : scan_code == 8'h1B ? 5'b00100 :
         scan_code == 8'h1C ? 5'b00010 : scan_code == 8'h23 ? 5'b00001 :
         scan_code == 8'h29 ? 5'b10000 : 5'b0;
    k2 = key_ext ? (scan_code == 8'h75 ? 5'b01000 : scan_code == 8'h72 ? 5'b00100 :
                    scan_code == 8'h6B ? 5'b00010 : scan_code == 8'h74 ? 5'b00001 : 5'b0)
                 : (scan_code == 8'h70 ? 5'b10000 : 5'b0);
    kr = !key_ext && scan_code == 8'h2D;
    kp = !key_ext && scan_code == 8'h4D;
  end

  // compose the frame word from pre-update state, then fold in this cycle's key event
  always_comb begin
    dir1   = pick(held_p1_q[3:0], last_p1_q);
    dir2   = pick(held_p2_q[3:0], last_p2_q);
    pw     = {held_p1_q[4], mv(dir1), held_p2_q[4], mv(dir2)};
    sched  = frame_tick && (!valid_q || instr_ready);
    word   = rst_q ? 8'hFF : pause_q ? 8'hFE : pw == 8'hFF ? 8'hF7 : pw;
    player = sched && !rst_q && !pause_q;
`ifdef KB_HOLD_EN
    con1 = 5'b0;
    con2 = 5'b0;
`else
    con1 = player ? {held_p1_q[4], dir1} : 5'b0;
    con2 = player ? {held_p2_q[4] && pw != 8'hFF, dir2} : 5'b0;
`endif
    held_p1_d = ((held_p1_q & ~con1) | (key_make ? k1 : 5'b0)) & ~(key_brk ? k1 : 5'b0);
    held_p2_d = ((held_p2_q & ~con2) | (key_make ? k2 : 5'b0)) & ~(key_brk ? k2 : 5'b0);
    last_p1_d = (key_make && |k1[3:0]) ? k1[3:0] : last_p1_q;
    last_p2_d = (key_make && |k2[3:0]) ? k2[3:0] : last_p2_q;
    rst_d     = (rst_q && !sched) || (key_make && kr);
    pause_d   = (pause_q && !(sched && !rst_q)) || (key_make && kp);
    valid_d   = sched ? word != 8'h00 : valid_q && !instr_ready;
    instr_d   = (sched && word != 8'h00) ? word : instr_q;
    drop_d    = (frame_tick && valid_q && !instr_ready && drop_q != '1) ? drop_q + 1'b1 : drop_q;
  end

  // key, one-shot and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held_p1_q <= '0;
      held_p2_q <= '0;
      last_p1_q <= '0;
      last_p2_q <= '0;
      rst_q     <= 1'b0;
      pause_q   <= 1'b0;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      drop_q    <= '0;
    end else begin
      held_p1_q <= held_p1_d;
      held_p2_q <= held_p2_d;
      last_p1_q <= last_p1_d;
      last_p2_q <= last_p2_d;
      rst_q     <= rst_d;
      pause_q   <= pause_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      drop_q    <= drop_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign held_p1     = held_p1_q;
  assign held_p2     = held_p2_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_kb_cmd_scheduler.sv
// tb_kb_cmd_scheduler: directed and randomized checks of kb_cmd_scheduler against a behavioural model.
module tb_kb_cmd_scheduler;
  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       scan_ready = 1'b0;
  logic       frame_tick = 1'b0;
  logic       instr_ready = 1'b0;
  logic [7:0] instr;
  logic       instr_valid;
  logic [4:0] held_p1, held_p2;
  logic [3:0] drop_count;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kb_cmd_scheduler #(.TIMEOUT_W(16), .PREFIX_TIMEOUT(TO), .DROP_W(4)) dut (
    .clk(clk), .reset(reset), .scan_code(scan_code), .scan_ready(scan_ready),
    .frame_tick(frame_tick), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .held_p1(held_p1), .held_p2(held_p2),
    .drop_count(drop_count)
  );

  // behavioural model: held sets, last direction index (0 up,1 down,2 left,3 right; -1 none)
  bit [4:0] m_held [2];
  int       m_last [2];
  bit       m_rst, m_pause, m_valid, m_ext, m_brk;
  bit [7:0] m_instr;
  int       m_drop, m_idle;
  logic [7:0] pool [16] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h70, 8'h2D, 8'h4D,
                            8'h75, 8'h72, 8'h6B, 8'h74, 8'hE0, 8'hF0, 8'hF0, 8'h12};

  task automatic model_reset();
    m_held[0] = 0; m_held[1] = 0; m_last[0] = -1; m_last[1] = -1;
    m_rst = 0; m_pause = 0; m_valid = 0; m_ext = 0; m_brk = 0;
    m_instr = 0; m_drop = 0; m_idle = 0;
  endtask

  function automatic int m_dir(int p);
    if (m_last[p] >= 0 && m_held[p][3 - m_last[p]]) return m_last[p];
    for (int d = 0; d < 4; d++) if (m_held[p][3 - d]) return d;
    return -1;
  endfunction

  function automatic bit [3:0] m_nib(int p);
    bit [2:0] codes [4] = '{3'b010, 3'b111, 3'b100, 3'b001};
    int d = m_dir(p);
    return {m_held[p][4], d < 0 ? 3'b000 : codes[d]};
  endfunction

  task automatic model_key(logic [7:0] code, bit ext, bit make);
    int p = -1;
    int b = -1;
    if (!ext) begin
      case (code)
        8'h1D: begin p = 0; b = 3; end
        8'h1B: begin p = 0; b = 2; end
        8'h1C: begin p = 0; b = 1; end
        8'h23: begin p = 0; b = 0; end
        8'h29: begin p = 0; b = 4; end
        8'h70: begin p = 1; b = 4; end
        8'h2D: if (make) m_rst = 1;
        8'h4D: if (make) m_pause = 1;
        default: ;
      endcase
    end else begin
      case (code)
        8'h75: begin p = 1; b = 3; end
        8'h72: begin p = 1; b = 2; end
        8'h6B: begin p = 1; b = 1; end
        8'h74: begin p = 1; b = 0; end
        default: ;
      endcase
    end
    if (p >= 0) begin
      m_held[p][b] = make;
      if (make && b < 4) m_last[p] = 3 - b;
    end
  endtask

  task automatic model_cycle(bit sr, logic [7:0] code, bit tick, bit rdy);
    bit xfer = m_valid && rdy;
    bit [7:0] w;
    int d0, d1;
    if (tick && (!m_valid || xfer)) begin
      if (m_rst) begin w = 8'hFF; m_rst = 0; end
      else if (m_pause) begin w = 8'hFE; m_pause = 0; end
      else begin
        d0 = m_dir(0);
        d1 = m_dir(1);
        w = {m_nib(0), m_nib(1)};
`ifndef KB_HOLD_EN
        if (d0 >= 0) m_held[0][3 - d0] = 0;
        if (d1 >= 0) m_held[1][3 - d1] = 0;
        m_held[0][4] = 0;
        if (w != 8'hFF) m_held[1][4] = 0;
`endif
        if (w == 8'hFF) w = 8'hF7;
      end
      m_valid = w != 0;
      if (w != 0) m_instr = w;
    end else if (tick && m_valid) begin
      if (m_drop < 15) m_drop++;
    end else if (xfer) m_valid = 0;
    if (sr) begin
      m_idle = 0;
      if (!m_ext && !m_brk && code == 8'hE0) m_ext = 1;
      else if (!m_brk && code == 8'hF0) m_brk = 1;
      else begin
        model_key(code, m_ext, !m_brk);
        m_ext = 0;
        m_brk = 0;
      end
    end else if (m_ext || m_brk) begin
      m_idle++;
      if (m_idle == TO) begin m_ext = 0; m_brk = 0; m_idle = 0; end
    end
  endtask

  task automatic step(bit sr, logic [7:0] code, bit tick, bit rdy);
    @(negedge clk);
    scan_ready = sr; scan_code = code; frame_tick = tick; instr_ready = rdy;
    model_cycle(sr, code, tick, rdy);
    @(posedge clk);
    #1;
    scan_ready = 0; frame_tick = 0;
  endtask

  task automatic send(logic [7:0] b);
    step(1, b, 0, 1);
  endtask

  task automatic tick(bit rdy);
    step(0, 8'h00, 1, rdy);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 0;
    model_reset();
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(negedge clk);
    checks++; if (instr !== 8'h00 || instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr got %h/%b exp 00/0", instr, instr_valid); end
    checks++; if (held_p1 !== 5'b0 || held_p2 !== 5'b0 || drop_count !== 4'h0) begin errors++; $display("FAIL reset_state got %b %b %h exp 0", held_p1, held_p2, drop_count); end
    reset = 1;
  endtask

  task automatic test_single_key();
    do_reset();
    send(8'h1D);
    checks++; if (held_p1 !== 5'b01000) begin errors++; $display("FAIL single_held got %b exp 01000", held_p1); end
    tick(1);
    checks++; if (instr_valid !== 1'b1 || instr !== 8'h20) begin errors++; $display("FAIL single_word got %h/%b exp 20/1", instr, instr_valid); end
    idle(1);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL single_xfer valid got %b exp 0", instr_valid); end
    send(8'hF0); send(8'h1D); tick(1);
    checks++; if (instr_valid !== 1'b0 || held_p1 !== 5'b0) begin errors++; $display("FAIL single_break got %b/%b exp 0/00000", instr_valid, held_p1); end
  endtask

  task automatic test_dir_resolve();
    do_reset();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'h72); tick(1);
    checks++; if (instr !== 8'h07 || instr_valid !== 1'b1) begin errors++; $display("FAIL dir_last got %h/%b exp 07/1", instr, instr_valid); end
    idle(1);
    send(8'hE0); send(8'hF0); send(8'h72); tick(1);
    checks++; if (instr !== 8'h02 || instr_valid !== 1'b1) begin errors++; $display("FAIL dir_fallback got %h/%b exp 02/1", instr, instr_valid); end
    idle(1);
  endtask

  task automatic test_collision();
    do_reset();
    send(8'h29); send(8'h1B); send(8'h70); send(8'hE0); send(8'h72); tick(1);
    checks++; if (instr !== 8'hF7) begin errors++; $display("FAIL collision got %h exp F7", instr); end
    idle(1); tick(1);
`ifdef KB_HOLD_EN
    checks++; if (instr !== 8'hF7) begin errors++; $display("FAIL collision_again got %h exp F7", instr); end
`else
    checks++; if (instr !== 8'h08) begin errors++; $display("FAIL collision_leftover got %h exp 08", instr); end
`endif
    idle(1);
  endtask

  task automatic test_oneshots();
    do_reset();
    send(8'h2D); send(8'h4D); send(8'h1D); tick(1);
    checks++; if (instr !== 8'hFF) begin errors++; $display("FAIL oneshot_reset got %h exp FF", instr); end
    idle(1); tick(1);
    checks++; if (instr !== 8'hFE) begin errors++; $display("FAIL oneshot_pause got %h exp FE", instr); end
    idle(1); tick(1);
    checks++; if (instr !== 8'h20 || drop_count !== 4'h0) begin errors++; $display("FAIL oneshot_deferred got %h/%h exp 20/0", instr, drop_count); end
    idle(1);
  endtask

  task automatic test_backpressure();
    do_reset();
    send(8'h1C); tick(0); tick(0); tick(0);
    checks++; if (instr !== 8'h40 || instr_valid !== 1'b1 || drop_count !== 4'h2) begin errors++; $display("FAIL bp_hold got %h/%b/%h exp 40/1/2", instr, instr_valid, drop_count); end
    step(0, 8'h00, 0, 1);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL bp_release valid got %b exp 0", instr_valid); end
    send(8'h1C); tick(0);
    for (int i = 0; i < 16; i++) tick(0);
    checks++; if (drop_count !== 4'hF || instr !== 8'h40) begin errors++; $display("FAIL bp_saturate got %h/%h exp F/40", drop_count, instr); end
    step(1, 8'h1D, 0, 0);
    step(0, 8'h00, 1, 1);
    checks++; if (instr_valid !== 1'b1 || instr !== 8'h20 || drop_count !== 4'hF) begin errors++; $display("FAIL bp_xfer_tick got %h/%b/%h exp 20/1/F", instr, instr_valid, drop_count); end
    idle(1);
  endtask

  task automatic test_timeout();
    do_reset();
    send(8'hF0); idle(TO + 5); send(8'h1C);
    checks++; if (held_p1 !== 5'b00010) begin errors++; $display("FAIL timeout_make got %b exp 00010", held_p1); end
    send(8'hF0); idle(10); send(8'h1C);
    checks++; if (held_p1 !== 5'b00000) begin errors++; $display("FAIL prefix_break got %b exp 00000", held_p1); end
  endtask

  task automatic test_async_reset();
    do_reset();
    send(8'h1C); tick(0); tick(0); step(1, 8'hF0, 0, 0);
    @(negedge clk);
    #2 reset = 0;
    #1;
    checks++; if (instr !== 8'h00 || instr_valid !== 1'b0 || held_p1 !== 5'b0 || held_p2 !== 5'b0 || drop_count !== 4'h0) begin errors++; $display("FAIL async_reset got %h %b %b %b %h exp all 0", instr, instr_valid, held_p1, held_p2, drop_count); end
    model_reset();
    @(negedge clk);
    reset = 1;
    send(8'h1C);
    checks++; if (held_p1 !== 5'b00010) begin errors++; $display("FAIL async_parser_idle got %b exp 00010", held_p1); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 1) == 1, pool[$urandom_range(0, 15)], $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7);
      checks++;
      if (instr !== m_instr || instr_valid !== m_valid || held_p1 !== m_held[0] || held_p2 !== m_held[1] || drop_count !== 4'(m_drop)) begin
        errors++;
        $display("FAIL random cyc %0d got %h %b %b %b %h exp %h %b %b %b %h", i, instr, instr_valid, held_p1, held_p2, drop_count, m_instr, m_valid, m_held[0], m_held[1], 4'(m_drop));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_dir_resolve();
    test_collision();
    test_oneshots();
    test_backpressure();
    test_timeout();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
